// File: rtl/ifq.sv
// Instruction prefetch queue feeding decode.
// Fetches 32-bit words and splits each into two big-endian 16-bit opcodes.
// Each opcode is queued with its PC, and decode sees one opcode per cycle.
// A redirect flushes the queue and restarts fetch at the new PC.
// Optional macro IFQ_BYPASS_EN forwards the first halfword of a fetch to decode
// in the transfer cycle when the queue is empty.
module ifq #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redir,
    input  logic [31:0] redir_pc,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic        op_v,
    output logic [15:0] op,
    output logic [31:0] op_pc,
    input  logic        op_take
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    // Queue storage: opcode and halfword PC (bit 0 is always zero)
    logic [15:0]   q_op   [DEPTH];
    logic [30:0]   q_pc   [DEPTH];
    logic [15:0]   q_op_n [DEPTH];
    logic [30:0]   q_pc_n [DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr, wr_n, rd_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          skip_hi, skip_n;
    logic          req_n;
    logic [31:0]   addr_n;

    logic          head_v;
    logic [15:0]   head_op;
    logic [31:0]   head_pc;

    logic          xfer;
    logic          deq;
    logic [1:0]    n_enq;
    logic [15:0]   en_op [2];
    logic [30:0]   en_pc [2];

    // Bit 0 of the redirect PC does not address anything
    logic          unused_pc0;
    assign unused_pc0 = redir_pc[0];

`ifdef IFQ_BYPASS_EN
    logic          byp_v;
    logic          byp_take;
    logic [15:0]   byp_op;
    logic [31:0]   byp_pc;
`endif

    // Next-state computation for queue, fetch address and request
    always_comb begin
        q_op_n   = q_op;
        q_pc_n   = q_pc;
        xfer     = bus_req & bus_ready & ~redir;
        deq      = (cnt != '0) & op_take & ~redir;
        en_op[0] = bus_rdata[31:16];
        en_pc[0] = {bus_addr[31:2], 1'b0};
        en_op[1] = bus_rdata[15:0];
        en_pc[1] = {bus_addr[31:2], 1'b1};
        n_enq    = xfer ? 2'd2 : 2'd0;

        // A redirect into the odd halfword drops the high half of the first word
        if (skip_hi) begin
            en_op[0] = bus_rdata[15:0];
            en_pc[0] = {bus_addr[31:2], 1'b1};
            n_enq    = xfer ? 2'd1 : 2'd0;
        end

`ifdef IFQ_BYPASS_EN
        byp_v    = xfer & (cnt == '0);
        byp_take = byp_v & op_take;
        byp_op   = en_op[0];
        byp_pc   = {en_pc[0], 1'b0};
        // A forwarded halfword consumed this cycle never enters the queue
        if (byp_take) begin
            en_op[0] = en_op[1];
            en_pc[0] = en_pc[1];
            n_enq    = n_enq - 2'd1;
        end
`endif

        if (n_enq != 2'd0) begin
            q_op_n[wr_ptr] = en_op[0];
            q_pc_n[wr_ptr] = en_pc[0];
        end
        if (n_enq == 2'd2) begin
            q_op_n[wr_ptr + AW'(1)] = en_op[1];
            q_pc_n[wr_ptr + AW'(1)] = en_pc[1];
        end

        wr_n   = wr_ptr + AW'(n_enq);
        rd_n   = rd_ptr + AW'(deq);
        cnt_n  = cnt + CW'(n_enq) - CW'(deq);
        addr_n = xfer ? (bus_addr + 32'd4) : bus_addr;
        skip_n = xfer ? 1'b0 : skip_hi;

        if (redir) begin
            wr_n   = '0;
            rd_n   = '0;
            cnt_n  = '0;
            addr_n = {redir_pc[31:2], 2'b00};
            skip_n = redir_pc[1];
        end

        // Hold an issued request until accepted; only issue when a whole word fits
        if (redir) begin
            req_n = 1'b1;
        end else if (bus_req & ~bus_ready) begin
            req_n = 1'b1;
        end else begin
            req_n = (cnt_n <= CW'(DEPTH - 2));
        end
    end

    // State registers, including the registered head-of-queue view
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_op     <= '{default: '0};
            q_pc     <= '{default: '0};
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            skip_hi  <= 1'b0;
            bus_req  <= 1'b0;
            bus_addr <= '0;
            head_v   <= 1'b0;
            head_op  <= '0;
            head_pc  <= '0;
        end else begin
            q_op     <= q_op_n;
            q_pc     <= q_pc_n;
            wr_ptr   <= wr_n;
            rd_ptr   <= rd_n;
            cnt      <= cnt_n;
            skip_hi  <= skip_n;
            bus_req  <= req_n;
            bus_addr <= addr_n;
            head_v   <= (cnt_n != '0);
            head_op  <= q_op_n[rd_n];
            head_pc  <= {q_pc_n[rd_n], 1'b0};
        end
    end

`ifdef IFQ_BYPASS_EN
    // Queue head when present, otherwise the halfword arriving this cycle
    always_comb begin
        op_v  = head_v | byp_v;
        op    = head_v ? head_op : byp_op;
        op_pc = head_v ? head_pc : byp_pc;
    end
`else
    // Decode sees the registered head only
    always_comb begin
        op_v  = head_v;
        op    = head_op;
        op_pc = head_pc;
    end
`endif

endmodule

// File: tb/tb_ifq.sv
// Directed bench for ifq with a scoreboard of expected opcode/PC pairs.
module tb_ifq;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        redir;
    logic [31:0] redir_pc;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        op_v;
    logic [15:0] op;
    logic [31:0] op_pc;
    logic        op_take;

    ifq #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .redir     (redir),
        .redir_pc  (redir_pc),
        .bus_req   (bus_req),
        .bus_addr  (bus_addr),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata),
        .op_v      (op_v),
        .op        (op),
        .op_pc     (op_pc),
        .op_take   (op_take)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] op;
        logic [31:0] pc;
    } ent_t;

    ent_t        sb[$];
    int          ncmp;
    int          nerr;
    logic        m_req;
    logic [31:0] m_addr;
    logic        m_skip;
    logic        auto_inc;
    logic [15:0] seq;
    logic [15:0] pop_seq;
    int          npop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_req  = 1'b0;
        m_addr = 32'h0;
        m_skip = 1'b0;
    endtask

    // Check outputs at the falling edge, then advance the model past the rising edge
    task automatic tick();
        bit xfer;
        ent_t e;
        xfer = 1'b0;
        @(negedge clk);
        chk("op_v", 32'(op_v), 32'(sb.size() != 0));
        chk("bus_req", 32'(bus_req), 32'(m_req));
        if (m_req) chk("bus_addr", bus_addr, m_addr);
        if (sb.size() != 0) begin
            chk("op", 32'(op), 32'(sb[0].op));
            chk("op_pc", op_pc, sb[0].pc);
        end
        if (!rst_n) begin
            model_reset();
        end else if (redir) begin
            sb.delete();
            m_addr = {redir_pc[31:2], 2'b00};
            m_skip = redir_pc[1];
            m_req  = 1'b1;
        end else begin
            xfer = m_req && bus_ready;
            if (op_take && sb.size() != 0) begin
                if (auto_inc) begin
                    chk("seq_op", 32'(op), 32'(pop_seq));
                    pop_seq = pop_seq + 16'd1;
                    npop++;
                end
                void'(sb.pop_front());
            end
            if (xfer) begin
                if (!m_skip) begin
                    e.op = bus_rdata[31:16];
                    e.pc = m_addr;
                    sb.push_back(e);
                end
                e.op = bus_rdata[15:0];
                e.pc = m_addr + 32'd2;
                sb.push_back(e);
                m_addr = m_addr + 32'd4;
                m_skip = 1'b0;
            end
            m_req = (m_req && !bus_ready) ? 1'b1 : (sb.size() <= int'(DEPTH) - 2);
        end
        @(posedge clk);
        #1;
        if (xfer && auto_inc) begin
            bus_rdata = {seq, seq + 16'd1};
            seq = seq + 16'd2;
        end
    endtask

    initial begin
        ncmp      = 0;
        nerr      = 0;
        npop      = 0;
        auto_inc  = 1'b0;
        seq       = 16'h0;
        pop_seq   = 16'h0;
        rst_n     = 1'b0;
        redir     = 1'b0;
        redir_pc  = 32'h0;
        bus_ready = 1'b0;
        bus_rdata = 32'h0;
        op_take   = 1'b0;
        model_reset();

        // Reset values
        #2;
        chk("rst_op_v", 32'(op_v), 0);
        chk("rst_bus_req", 32'(bus_req), 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_op", 32'(op), 0);
        chk("rst_op_pc", op_pc, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Sequential fill from 0x100 until full, then drain with the bus stalled
        redir     = 1'b1;
        redir_pc  = 32'h0000_0100;
        bus_ready = 1'b1;
        bus_rdata = 32'h1111_2222;
        tick();
        redir = 1'b0;
        tick();
        bus_rdata = 32'h3333_4444;
        tick();
        tick();
        tick();
        chk("t1_full_req", 32'(bus_req), 0);
        chk("t1_head_op", 32'(op), 32'h1111);
        chk("t1_head_pc", op_pc, 32'h100);
        bus_ready = 1'b0;
        op_take   = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("t5_req_held", 32'(bus_req), 1);
        chk("t5_addr_held", bus_addr, 32'h108);
        chk("t5_drained", 32'(op_v), 0);
        tick();
        op_take = 1'b0;

        // Redirect to an odd halfword keeps only the low half of the first word
        redir     = 1'b1;
        redir_pc  = 32'h0000_0202;
        bus_ready = 1'b1;
        bus_rdata = 32'hAAAA_BBBB;
        tick();
        redir = 1'b0;
        tick();
        bus_ready = 1'b0;
        chk("t2_op_v", 32'(op_v), 1);
        chk("t2_op", 32'(op), 32'hBBBB);
        chk("t2_op_pc", op_pc, 32'h202);
        chk("t2_next_addr", bus_addr, 32'h204);
        tick();
        op_take = 1'b1;
        tick();
        op_take = 1'b0;
        tick();

        // Streaming with decode always taking: no loss or duplication
        auto_inc  = 1'b1;
        bus_rdata = 32'h0000_0001;
        seq       = 16'h2;
        pop_seq   = 16'h0;
        npop      = 0;
        bus_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        op_take = 1'b1;
        for (int i = 0; i < 300 && npop < 64; i++) tick();
        chk("t3_pop_count", 32'(npop >= 64), 1);
        auto_inc  = 1'b0;
        op_take   = 1'b0;
        bus_ready = 1'b0;
        tick();

        // Redirect coinciding with an accepted transfer discards the word
        redir     = 1'b1;
        redir_pc  = 32'h0000_0300;
        bus_rdata = 32'h5555_6666;
        tick();
        redir_pc  = 32'h0000_0400;
        bus_ready = 1'b1;
        tick();
        redir     = 1'b0;
        bus_ready = 1'b0;
        chk("t4_op_v", 32'(op_v), 0);
        chk("t4_req", 32'(bus_req), 1);
        chk("t4_addr", bus_addr, 32'h400);
        tick();

        // Fetch address wraps at the top of memory
        redir     = 1'b1;
        redir_pc  = 32'hFFFF_FFFC;
        bus_ready = 1'b1;
        bus_rdata = 32'hCAFE_F00D;
        tick();
        redir = 1'b0;
        tick();
        bus_ready = 1'b0;
        chk("wrap_addr", bus_addr, 32'h0);
        chk("wrap_op", 32'(op), 32'hCAFE);
        chk("wrap_op_pc", op_pc, 32'hFFFF_FFFC);
        tick();

        // Asynchronous reset in the middle of a transfer
        bus_ready = 1'b1;
        bus_rdata = 32'h7777_8888;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_op_v", 32'(op_v), 0);
        chk("arst_bus_req", 32'(bus_req), 0);
        chk("arst_bus_addr", bus_addr, 0);
        chk("arst_op", 32'(op), 0);
        chk("arst_op_pc", op_pc, 0);
        model_reset();
        tick();
        rst_n     = 1'b1;
        bus_ready = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
